// File: rtl/game_pkg.sv
// Shared definitions for the stacking-game sequencer: play states, default
// tuning values and a saturating 4-digit BCD increment.
package game_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_SPAWN  = 3'd2,
    S_FALL   = 3'd3,
    S_PAUSED = 3'd4,
    S_LANDED = 3'd5,
    S_OVER   = 3'd6
  } state_e;

  localparam logic [9:0] MAX_HEIGHT_DEF = 10'd400;
  localparam logic [1:0] LIVES_DEF      = 2'd3;
  localparam int         LEVEL_STEP_DEF = 5;
  localparam logic [2:0] MAX_LEVEL_DEF  = 3'd7;

  // Ripple a +1 through four BCD digits; 9999 is sticky.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw button followed by a registered rising-edge
// detector; a held button yields one pulse, three clocks after the press.
module btn_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q, pulse_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      pulse_q <= sync2_q & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/game_ctrl.sv
// Play sequencer for the stacking game: owns the play FSM, paces the falling
// item with step pulses and keeps BCD score, level and lives.
module game_ctrl
  import game_pkg::*;
#(
  parameter logic [9:0] MAX_HEIGHT = MAX_HEIGHT_DEF,
  parameter logic [1:0] LIVES      = LIVES_DEF,
  parameter int         LEVEL_STEP = LEVEL_STEP_DEF,
  parameter logic [2:0] MAX_LEVEL  = MAX_LEVEL_DEF
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_btn_i,
  input  logic        pause_btn_i,
  input  logic        fall_tick_i,
  input  logic        collision_i,
  input  logic        miss_i,
  input  logic [9:0]  stack_height_i,
  output logic        run_en_o,
  output logic        step_o,
  output logic        spawn_o,
  output logic        clear_o,
  output logic [2:0]  state_o,
  output logic [15:0] score_o,
  output logic [2:0]  level_o,
  output logic [1:0]  lives_o,
  output logic        game_over_o
);

  localparam int CW = $clog2(LEVEL_STEP + 1);

  logic start_pe, pause_pe;

  btn_edge u_start_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (start_btn_i),
    .pulse_o (start_pe)
  );

  btn_edge u_pause_edge (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .btn_i   (pause_btn_i),
    .pulse_o (pause_pe)
  );

  state_e          state_q, state_d;
  logic [2:0]      div_q, div_d;
  logic [CW-1:0]   catch_q, catch_d;
  logic [15:0]     score_q, score_d;
  logic [2:0]      level_q, level_d;
  logic [1:0]      lives_q, lives_d;
  logic            step_d;
  logic            run_en_q, step_q, spawn_q, clear_q, game_over_q;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    catch_d = catch_q;
    score_d = score_q;
    level_d = level_q;
    lives_d = lives_q;
    step_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_pe) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        score_d = '0;
        level_d = '0;
        lives_d = LIVES;
        catch_d = '0;
        state_d = S_SPAWN;
      end
      S_SPAWN: begin
        div_d   = '0;
        state_d = S_FALL;
      end
      S_FALL: begin
        if (start_pe) begin
          state_d = S_CLEAR;
        end else if (pause_pe) begin
          state_d = S_PAUSED;
        end else if (collision_i) begin
          state_d = S_LANDED;
        end else if (miss_i) begin
          if (lives_q <= 2'd1) begin
            lives_d = '0;
            state_d = S_OVER;
          end else begin
            lives_d = lives_q - 2'd1;
            state_d = S_SPAWN;
          end
        end else if (fall_tick_i) begin
          // Higher levels shorten the tick count between steps.
          if (div_q == (MAX_LEVEL - level_q)) begin
            step_d = 1'b1;
            div_d  = '0;
          end else begin
            div_d = div_q + 3'd1;
          end
        end
      end
      S_PAUSED: begin
        if (start_pe)      state_d = S_CLEAR;
        else if (pause_pe) state_d = S_FALL;
      end
      S_LANDED: begin
        score_d = bcd_inc(score_q);
        if (catch_q == CW'(LEVEL_STEP - 1)) begin
          catch_d = '0;
          if (level_q != MAX_LEVEL) level_d = level_q + 3'd1;
        end else begin
          catch_d = catch_q + CW'(1);
        end
        state_d = (stack_height_i >= MAX_HEIGHT) ? S_OVER : S_SPAWN;
      end
      S_OVER: begin
        if (start_pe) state_d = S_CLEAR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_o.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      catch_q     <= '0;
      score_q     <= '0;
      level_q     <= '0;
      lives_q     <= '0;
      run_en_q    <= 1'b0;
      step_q      <= 1'b0;
      spawn_q     <= 1'b0;
      clear_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      catch_q     <= catch_d;
      score_q     <= score_d;
      level_q     <= level_d;
      lives_q     <= lives_d;
      run_en_q    <= (state_d == S_FALL);
      step_q      <= step_d;
      spawn_q     <= (state_d == S_SPAWN);
      clear_q     <= (state_d == S_CLEAR);
      game_over_q <= (state_d == S_OVER);
    end
  end

  assign state_o     = state_q;
  assign run_en_o    = run_en_q;
  assign step_o      = step_q;
  assign spawn_o     = spawn_q;
  assign clear_o     = clear_q;
  assign score_o     = score_q;
  assign level_o     = level_q;
  assign lives_o     = lives_q;
  assign game_over_o = game_over_q;

endmodule
